block_ctrl: RTL and testbench

Falling-piece motion controller for the Tetris playfield. It sits directly upstream of the block sprite source and drives that stage's sprite origin (`x0`, `y0`) and 4-bit `ctrl` sprite select. It spawns a piece and applies gravity, left/right moves, rotation and hard drop once per video frame. It signals when the piece reaches the playfield floor.

---
 rtl/block_ctrl.sv | 147 ++++++++++++++
 tb/tb_block_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/block_ctrl.sv
// Falling-piece motion controller: spawns a sprite, applies per-frame gravity, moves,
// rotation and hard drop, and pulses landed when the piece reaches the floor.
module block_ctrl #(
  parameter int unsigned FIELD_LEFT   = 192,
  parameter int unsigned FIELD_RIGHT  = 448,
  parameter int unsigned FIELD_TOP    = 0,
  parameter int unsigned FIELD_BOTTOM = 480,
  parameter int unsigned SPAWN_X      = 304,
  parameter int unsigned STEP         = 8,
  parameter int unsigned GRAV_TICKS   = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        refr_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_rot,
  input  logic        btn_drop,
  input  logic        spawn,
  input  logic [1:0]  piece_in,
  output logic [10:0] x0,
  output logic [10:0] y0,
  output logic [3:0]  ctrl,
  output logic        active,
  output logic        landed
);

  localparam int unsigned GW = (GRAV_TICKS > 1) ? $clog2(GRAV_TICKS) : 1;

  localparam logic [11:0] LEFT_MIN  = 12'(FIELD_LEFT + STEP);
  localparam logic [11:0] RIGHT_MAX = 12'(FIELD_RIGHT - 32);
  localparam logic [11:0] BOTTOM    = 12'(FIELD_BOTTOM);
  localparam logic [11:0] STEP12    = 12'(STEP);
  localparam logic [10:0] STEP11    = 11'(STEP);
  localparam logic [GW-1:0] GRAV_LAST = GW'(GRAV_TICKS - 1);

  // Button vector bit order: {left, right, rot, drop}
  localparam int unsigned BL = 3;
  localparam int unsigned BR = 2;
  localparam int unsigned BT = 1;
  localparam int unsigned BD = 0;

  typedef enum logic [0:0] {StIdle, StFall} state_e;

  state_e          state_q, state_d;
  logic [10:0]     x0_q, x0_d, y0_q, y0_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic            landed_q, landed_d;
  logic [GW-1:0]   grav_q, grav_d;
  logic            drop_q, drop_d;
  logic [3:0]      prev_q, prev_d;
  logic [3:0]      pend_q, pend_d;

  logic [3:0]      btns, edges, req;
  logic            drop_eff, descend;

  assign btns  = {btn_left, btn_right, btn_rot, btn_drop};
  assign edges = btns & ~prev_q;
  assign req   = pend_q | edges;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      x0_q     <= 11'(SPAWN_X);
      y0_q     <= 11'(FIELD_TOP);
      ctrl_q   <= 4'd0;
      landed_q <= 1'b0;
      grav_q   <= '0;
      drop_q   <= 1'b0;
      // Held buttons at reset release must not register as edges
      prev_q   <= 4'hF;
      pend_q   <= 4'h0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      ctrl_q   <= ctrl_d;
      landed_q <= landed_d;
      grav_q   <= grav_d;
      drop_q   <= drop_d;
      prev_q   <= prev_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    ctrl_d   = ctrl_q;
    landed_d = 1'b0;
    grav_d   = grav_q;
    drop_d   = drop_q;
    prev_d   = btns;
    pend_d   = pend_q;
    drop_eff = drop_q | req[BD];
    descend  = drop_eff | (grav_q == GRAV_LAST);

    unique case (state_q)
      StIdle: begin
        pend_d = 4'h0;
        if (spawn) begin
          x0_d    = 11'(SPAWN_X);
          y0_d    = 11'(FIELD_TOP);
          ctrl_d  = {piece_in, 2'b00};
          grav_d  = '0;
          drop_d  = 1'b0;
          state_d = StFall;
        end
      end
      StFall: begin
        if (refr_tick) begin
          pend_d = 4'h0;
          if (req[BT]) ctrl_d[1:0] = ctrl_q[1:0] + 2'd1;
          if (req[BL] && !req[BR]) begin
            if ({1'b0, x0_q} >= LEFT_MIN) x0_d = x0_q - STEP11;
          end else if (req[BR] && !req[BL]) begin
            if ({1'b0, x0_q} + STEP12 <= RIGHT_MAX) x0_d = x0_q + STEP11;
          end
          drop_d = drop_eff;
          if (descend) begin
            grav_d = '0;
            if ({1'b0, y0_q} + 12'd32 + STEP12 <= BOTTOM) begin
              y0_d = y0_q + STEP11;
            end else begin
              landed_d = 1'b1;
              drop_d   = 1'b0;
              state_d  = StIdle;
            end
          end else begin
            grav_d = grav_q + 1'b1;
          end
        end else begin
          pend_d = pend_q | edges;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign x0     = x0_q;
  assign y0     = y0_q;
  assign ctrl   = ctrl_q;
  assign active = (state_q == StFall);
  assign landed = landed_q;

endmodule

// File: tb/tb_block_ctrl.sv
// Directed bench for block_ctrl: spawn, gravity, walls, rotation, hard drop, reset mid-fall.
module tb_block_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        refr_tick = 1'b0;
  logic        btn_left = 1'b0, btn_right = 1'b0, btn_rot = 1'b0, btn_drop = 1'b0;
  logic        spawn = 1'b0;
  logic [1:0]  piece_in = 2'd0;
  logic [10:0] x0, y0;
  logic [3:0]  ctrl;
  logic        active, landed;

  int checks = 0;
  int errors = 0;

  block_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .refr_tick (refr_tick),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_rot   (btn_rot),
    .btn_drop  (btn_drop),
    .spawn     (spawn),
    .piece_in  (piece_in),
    .x0        (x0),
    .y0        (y0),
    .ctrl      (ctrl),
    .active    (active),
    .landed    (landed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse refr_tick for one cycle; returns on the negedge after the update edge
  task automatic tick();
    @(negedge clk) refr_tick = 1'b1;
    @(negedge clk) refr_tick = 1'b0;
  endtask

  task automatic press(input int b);
    @(negedge clk);
    case (b)
      0: btn_left = 1'b1;
      1: btn_right = 1'b1;
      2: btn_rot = 1'b1;
      default: btn_drop = 1'b1;
    endcase
    @(negedge clk);
    btn_left = 1'b0; btn_right = 1'b0; btn_rot = 1'b0; btn_drop = 1'b0;
  endtask

  task automatic do_spawn(input logic [1:0] p);
    @(negedge clk) begin spawn = 1'b1; piece_in = p; end
    @(negedge clk) spawn = 1'b0;
  endtask

  initial begin
    int exp_x;
    logic [1:0] rot_seq [5];
    rot_seq[0] = 2'd1; rot_seq[1] = 2'd2; rot_seq[2] = 2'd3; rot_seq[3] = 2'd0;
    rot_seq[4] = 2'd1;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_x0", 32'(x0), 304);
    chk("rst_y0", 32'(y0), 0);
    chk("rst_ctrl", 32'(ctrl), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_landed", 32'(landed), 0);

    // Spawn and gravity
    do_spawn(2'd2);
    chk("spawn_ctrl", 32'(ctrl), 8);
    chk("spawn_x0", 32'(x0), 304);
    chk("spawn_y0", 32'(y0), 0);
    chk("spawn_active", 32'(active), 1);
    repeat (29) tick();
    chk("grav_29", 32'(y0), 0);
    tick();
    chk("grav_30", 32'(y0), 8);

    // Left wall: 14 real moves then saturation at 192
    for (int i = 1; i <= 20; i++) begin
      press(0);
      tick();
      exp_x = 304 - 8 * i;
      if (exp_x < 192) exp_x = 192;
      chk($sformatf("left_%0d", i), 32'(x0), 32'(exp_x));
    end
    press(0);
    tick();
    chk("left_sat", 32'(x0), 192);

    // Left and right together cancel
    @(negedge clk) begin btn_left = 1'b1; btn_right = 1'b1; end
    @(negedge clk) begin btn_left = 1'b0; btn_right = 1'b0; end
    tick();
    chk("lr_both", 32'(x0), 192);

    // Rotation wraps, slot unchanged
    for (int i = 0; i < 5; i++) begin
      press(2);
      tick();
      chk($sformatf("rot_%0d", i), 32'(ctrl), 32'({2'd2, rot_seq[i]}));
    end

    // Right move from 192
    press(1);
    tick();
    chk("right_1", 32'(x0), 200);

    // Hard drop on a fresh piece
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    do_spawn(2'd1);
    press(3);
    for (int i = 1; i <= 56; i++) begin
      if (i == 20) begin
        @(negedge clk) begin spawn = 1'b1; piece_in = 2'd3; end
        @(negedge clk) spawn = 1'b0;
      end
      tick();
    end
    chk("drop_y448", 32'(y0), 448);
    chk("drop_active56", 32'(active), 1);
    chk("drop_ctrl_spawn_ignored", 32'(ctrl), 4);
    tick();
    chk("land_pulse", 32'(landed), 1);
    chk("land_active", 32'(active), 0);
    chk("land_y0", 32'(y0), 448);
    @(negedge clk);
    chk("land_pulse_end", 32'(landed), 0);
    tick();
    chk("idle_hold_y0", 32'(y0), 448);

    // Reset mid-fall with drop held
    do_spawn(2'd3);
    @(negedge clk) btn_drop = 1'b1;
    repeat (25) tick();
    chk("mid_y200", 32'(y0), 200);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("midrst_landed", 32'(landed), 0);
    chk("midrst_active", 32'(active), 0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    chk("midrst_x0", 32'(x0), 304);
    chk("midrst_y0", 32'(y0), 0);
    chk("midrst_ctrl", 32'(ctrl), 0);
    chk("midrst_landed2", 32'(landed), 0);
    do_spawn(2'd3);
    repeat (29) tick();
    chk("held_drop_no_req", 32'(y0), 0);
    btn_drop = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
